uart_tx_mmio: RTL and testbench

UART_TX_MMIO -- requirements
Module: uart_tx_mmio

---
 rtl/uart_tx_mmio.sv | 192 +++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: byte FIFO written over a simple bus,
// drained by an 8N1 serializer with a programmable bit period.
module uart_tx_mmio #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        RSTN,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        busy
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = 16;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [1:0]        ADDR_DATA = 2'd0;
    localparam logic [1:0]        ADDR_STAT = 2'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state, state_next;
    logic [BAUD_W-1:0]  baud, baud_next;
    logic [7:0]         shift, shift_next;
    logic [2:0]         bit_idx, bit_next;
    logic               tx_next;
    logic               busy_next;
    logic               pop;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               overflow;

    logic               empty, full, push, ovf_set, ovf_clr, baud_last;
    logic               unused;

    assign empty     = (count == '0);
    assign full      = (count == CNT_FULL);
    assign push      = RSTN && we && (addr == ADDR_DATA) && !full;
    assign ovf_set   = we && (addr == ADDR_DATA) && full;
    assign ovf_clr   = we && (addr == ADDR_STAT);
    assign baud_last = (baud == BAUD_LAST);
    assign unused    = ^wdata[31:8];

    // FSM state and serializer registers
    always_ff @(posedge clk) begin
        if (!RSTN) begin
            state   <= IDLE;
            baud    <= '0;
            shift   <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_next;
            baud    <= baud_next;
            shift   <= shift_next;
            bit_idx <= bit_next;
            tx      <= tx_next;
            busy    <= busy_next;
        end
    end

    // Next-state logic: frame sequencing, baud timing, and FIFO pop requests
    always_comb begin
        state_next = state;
        baud_next  = baud;
        shift_next = shift;
        bit_next   = bit_idx;
        tx_next    = tx;
        pop        = 1'b0;

        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = START;
                    shift_next = mem[rd_ptr];
                    tx_next    = 1'b0;
                    baud_next  = '0;
                end
            end
            START: begin
                if (baud_last) begin
                    state_next = DATA;
                    tx_next    = shift[0];
                    baud_next  = '0;
                    bit_next   = '0;
                end else begin
                    baud_next = baud + 16'd1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        tx_next  = shift[1];
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    baud_next = baud + 16'd1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_next = '0;
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = START;
                        shift_next = mem[rd_ptr];
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end
                end else begin
                    baud_next = baud + 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                baud_next  = '0;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    // FIFO storage; contents need no reset since pointers and count do
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!RSTN) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Combinational register read mux; only STATUS carries data
    always_comb begin
        rdata = '0;
        if (addr == ADDR_STAT) begin
            rdata[0]    = empty;
            rdata[1]    = full;
            rdata[2]    = busy;
            rdata[3]    = overflow;
            rdata[15:8] = 8'(count);
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: directed scenarios plus random bus
// traffic, compared every cycle against a frame-timeline reference model.
module tb_uart_tx_mmio;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;
    localparam int HIST  = 8192;

    logic        clk   = 1'b0;
    logic        RSTN  = 1'b0;
    logic        we    = 1'b0;
    logic [1:0]  addr  = 2'd0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        tx;
    logic        busy;

    uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .RSTN  (RSTN),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc   = 0;
    logic [7:0] q[$];
    int         fpos  = -1;
    logic [7:0] cur   = 8'h00;
    logic       ovf_m = 1'b0;
    logic       tx_hist [HIST];

    // Expected line level from the position inside the current 10-bit frame
    function automatic logic exp_tx();
        int bitn;
        if (fpos < 0) return 1'b1;
        bitn = fpos / CPB;
        if (bitn == 0) return 1'b0;
        if (bitn <= 8) return cur[bitn-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_status();
        return {16'h0, 8'(q.size()), 4'h0, ovf_m, (fpos >= 0),
                (q.size() == DEPTH), (q.size() == 0)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: advance one clock edge using the currently driven bus
    task automatic model_edge();
        logic full_pre, do_pop;
        if (!RSTN) begin
            q.delete();
            fpos  = -1;
            ovf_m = 1'b0;
            return;
        end
        full_pre = (q.size() == DEPTH);
        do_pop   = ((fpos < 0) || (fpos == FRAME - 1)) && (q.size() > 0);
        if (do_pop) cur = q.pop_front();
        if (we && addr == 2'd0 && !full_pre) q.push_back(wdata[7:0]);
        if (we && addr == 2'd0 && full_pre) ovf_m = 1'b1;
        else if (we && addr == 2'd1) ovf_m = 1'b0;
        if (do_pop) fpos = 0;
        else if (fpos == FRAME - 1) fpos = -1;
        else if (fpos >= 0) fpos = fpos + 1;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        we   = 1'b0;
        addr = 2'd1;
        #1;
        cyc++;
        if (cyc < HIST) tx_hist[cyc] = tx;
        chk("tx", 32'(tx), 32'(exp_tx()));
        chk("busy", 32'(busy), 32'(fpos >= 0));
        chk("status", rdata, exp_status());
        if ((cyc % 4) != 1) begin
            addr = 2'(cyc % 4);
            #1;
            chk("rd_zero", rdata, 32'h0);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        step();
    endtask

    task automatic idle();
        we = 1'b0;
        step();
    endtask

    task automatic rd_status(output logic [31:0] v);
        addr = 2'd1;
        #1;
        v = rdata;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (busy === 1'b1 && n < lim) begin
            idle();
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'h0);
    endtask

    function automatic logic [7:0] decode(input int n0);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b[i] = tx_hist[n0 + 6 + CPB * i];
        end
        return b;
    endfunction

    initial begin
        logic [31:0] st;
        int          n0, cnt, nb, r;

        // Reset with bus writes that must be ignored
        RSTN = 1'b0;
        for (int i = 0; i < 3; i++) wr(2'd0, 32'hAA);
        rd_status(st);
        chk("rst_status", st, 32'h1);
        chk("rst_tx", 32'(tx), 32'h1);
        RSTN = 1'b1;
        idle();

        // Single byte: busy falls 41 edges after the push
        wr(2'd0, 32'h55);
        n0  = cyc;
        cnt = 0;
        do begin
            idle();
            cnt++;
        end while (busy === 1'b1 && cnt < 100);
        chk("single_busy_len", 32'(cnt), 32'd41);
        chk("single_start", 32'(tx_hist[n0+1]), 32'h0);
        chk("single_byte", 32'(decode(n0)), 32'h55);

        // Back-to-back frames with no idle gap
        wr(2'd0, 32'hA5);
        n0 = cyc;
        wr(2'd0, 32'h3C);
        nb  = (busy === 1'b1) ? 1 : 0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            idle();
            cnt++;
            if (busy === 1'b1) nb++;
        end
        chk("b2b_busy_len", 32'(nb), 32'd80);
        chk("b2b_stop_end", 32'(tx_hist[n0+40]), 32'h1);
        chk("b2b_second_start", 32'(tx_hist[n0+41]), 32'h0);
        chk("b2b_byte1", 32'(decode(n0)), 32'hA5);
        chk("b2b_byte2", 32'(decode(n0 + FRAME)), 32'h3C);

        // Overflow while transmitting, then clear
        wr(2'd0, 32'h01);
        for (int i = 0; i < 6; i++) wr(2'd0, 32'h10 + 32'(i));
        rd_status(st);
        chk("ovf_full", st, 32'h0000_040E);
        wr(2'd1, 32'h0);
        rd_status(st);
        chk("ovf_cleared", st, 32'h0000_0406);

        // Overflow set again by a dropped push after a clear
        wr(2'd0, 32'h99);
        wr(2'd1, 32'h0);
        wr(2'd0, 32'h98);
        rd_status(st);
        chk("ovf_reset_again", st, 32'h0000_040E);
        wr(2'd1, 32'h0);
        wait_idle(400);

        // Reset during data bit 3 of 0xFF with two bytes queued
        wr(2'd0, 32'hFF);
        n0 = cyc;
        wr(2'd0, 32'h11);
        wr(2'd0, 32'h22);
        while (cyc < n0 + 18) idle();
        RSTN = 1'b0;
        idle();
        RSTN = 1'b1;
        rd_status(st);
        chk("midrst_status", st, 32'h1);
        chk("midrst_tx", 32'(tx), 32'h1);
        chk("midrst_busy", 32'(busy), 32'h0);
        n0 = cyc;
        for (int i = 0; i < 60; i++) idle();
        for (int i = 1; i <= 60; i++) begin
            if (!tx_hist[n0+i]) begin
                chk("midrst_no_frame", 32'h0, 32'h1);
                break;
            end
        end

        // Pointer wrap: ten bytes pushed and drained one at a time
        for (int b = 0; b < 10; b++) begin
            wr(2'd0, 32'(b));
            n0 = cyc;
            idle();
            wait_idle(100);
            chk("wrap_byte", 32'(decode(n0)), 32'(b));
            rd_status(st);
            chk("wrap_empty", st, 32'h1);
        end

        // Random bus traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            r     = int'($urandom_range(0, 199));
            RSTN  = (r < 2) ? 1'b0 : 1'b1;
            we    = (r < 80) ? 1'b1 : 1'b0;
            addr  = (r < 60) ? 2'd0 : 2'($urandom_range(0, 3));
            wdata = $urandom;
            step();
        end
        RSTN = 1'b1;
        wait_idle(400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
